pipelined_cla_adder: RTL and testbench

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/pipelined_cla_adder.sv | 264 ++++++++++++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
//
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshakes on both sides.
//
//   Stage S1 registers the per-bit generate/propagate terms, the per-nibble
//   group generate/propagate, the effective carry-in and the operand sign bits.
//   Stage S2 resolves the group carries with a second-level lookahead, expands
//   them into in-nibble carries and registers sum/cout/ovf/zero.
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous, active-high; clears both valid bits and the
//                result registers
//   in_valid   : operand set (a, b, cin, sub) presented this cycle
//   in_ready   : operand set is accepted this cycle when in_valid is also high
//   a, b       : WIDTH-bit operands
//   cin        : carry-in for addition (ignored when sub=1)
//   sub        : 0 -> a + b + cin, 1 -> a - b (a + ~b + 1)
//   out_valid  : sum/cout/ovf/zero hold a valid result
//   out_ready  : downstream consumes the result this cycle
//   sum        : WIDTH-bit result
//   cout       : carry out of the MSB (for subtraction 1 = no borrow)
//   ovf        : two's-complement signed overflow
//   zero       : result is all zeros
//
// WIDTH must be a multiple of 4 in the range 4..64.
// -----------------------------------------------------------------------------
module pipelined_cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / 4;

    // -------------------------------------------------------------------------
    // 4-bit lookahead helpers
    // -------------------------------------------------------------------------

    // Group generate of one nibble: G = g3 | p3g2 | p3p2g1 | p3p2p1g0.
    function automatic logic grp_generate(input logic [3:0] g, input logic [3:0] p);
        return g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    // Group propagate of one nibble: P = p0p1p2p3.
    function automatic logic grp_propagate(input logic [3:0] p);
        return &p;
    endfunction

    // Carries into each bit of a nibble, all expressed directly from c0 so no
    // bit waits on its neighbour's carry.
    function automatic logic [3:0] grp_carries(input logic [3:0] g,
                                               input logic [3:0] p,
                                               input logic       c0);
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    // -------------------------------------------------------------------------
    // Handshake control
    // -------------------------------------------------------------------------
    logic s1_load_s;
    logic s2_load_s;

    // S1 register contents
    logic             v1_r;
    logic [WIDTH-1:0] g1_r;
    logic [WIDTH-1:0] p1_r;
    logic [NG-1:0]    gg1_r;
    logic [NG-1:0]    gp1_r;
    logic             c1_r;
    logic             sa1_r;
    logic             sb1_r;

    // S2 register contents
    logic             v2_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;

    // S2 drains whenever it is empty or its result is being taken; S1 refills
    // whenever its contents can move on (or it is empty).
    assign s2_load_s = !v2_r || out_ready;
    assign in_ready  = !v1_r || !v2_r || out_ready;
    assign s1_load_s = in_ready;

    // -------------------------------------------------------------------------
    // Stage 1 combinational: operand conditioning and nibble G/P
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] p_s;
    logic [NG-1:0]    gg_s;
    logic [NG-1:0]    gp_s;
    logic             cin_eff_s;

    // Invert b for subtraction and derive bit and nibble generate/propagate.
    always_comb begin
        b_eff_s   = sub ? ~b : b;
        g_s       = a & b_eff_s;
        p_s       = a ^ b_eff_s;
        cin_eff_s = sub ? 1'b1 : cin;
        gg_s      = {NG{1'b0}};
        gp_s      = {NG{1'b0}};
        for (int k = 0; k < NG; k++) begin
            gg_s[k] = grp_generate(g_s[4*k +: 4], p_s[4*k +: 4]);
            gp_s[k] = grp_propagate(p_s[4*k +: 4]);
        end
    end

    // Stage 1 register: capture conditioned operands on acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_r  <= 1'b0;
            g1_r  <= {WIDTH{1'b0}};
            p1_r  <= {WIDTH{1'b0}};
            gg1_r <= {NG{1'b0}};
            gp1_r <= {NG{1'b0}};
            c1_r  <= 1'b0;
            sa1_r <= 1'b0;
            sb1_r <= 1'b0;
        end else if (s1_load_s) begin
            v1_r <= in_valid;
            // Data only changes on a real acceptance so an idle S1 keeps its
            // last operands instead of toggling on bubbles.
            if (in_valid) begin
                g1_r  <= g_s;
                p1_r  <= p_s;
                gg1_r <= gg_s;
                gp1_r <= gp_s;
                c1_r  <= cin_eff_s;
                sa1_r <= a[WIDTH-1];
                sb1_r <= b_eff_s[WIDTH-1];
            end else begin
                g1_r  <= g1_r;
                p1_r  <= p1_r;
                gg1_r <= gg1_r;
                gp1_r <= gp1_r;
                c1_r  <= c1_r;
                sa1_r <= sa1_r;
                sb1_r <= sb1_r;
            end
        end else begin
            v1_r  <= v1_r;
            g1_r  <= g1_r;
            p1_r  <= p1_r;
            gg1_r <= gg1_r;
            gp1_r <= gp1_r;
            c1_r  <= c1_r;
            sa1_r <= sa1_r;
            sb1_r <= sb1_r;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2 combinational: second-level lookahead and result formation
    // -------------------------------------------------------------------------
    logic [NG:0]      gc_s;     // gc_s[k] = carry into nibble k, gc_s[NG] = cout
    logic [WIDTH-1:0] carry_s;  // carry into every bit position
    logic [WIDTH-1:0] sum_s;
    logic             cout_s;
    logic             ovf_s;
    logic             zero_s;
    logic             acc_s;
    logic             term_s;

    // Group carries as a flat sum of products over the registered G/P:
    //   C[k] = OR_j<k ( G[j] & P[j+1..k-1] )  |  ( cin & P[0..k-1] )
    // Every term is built directly from registered values; no group carry is
    // derived from a previous group carry.
    always_comb begin
        gc_s   = {(NG+1){1'b0}};
        acc_s  = 1'b0;
        term_s = 1'b0;
        for (int k = 0; k <= NG; k++) begin
            acc_s = c1_r;
            for (int m = 0; m < k; m++) begin
                acc_s = acc_s & gp1_r[m];
            end
            for (int j = 0; j < k; j++) begin
                term_s = gg1_r[j];
                for (int m = j + 1; m < k; m++) begin
                    term_s = term_s & gp1_r[m];
                end
                acc_s = acc_s | term_s;
            end
            gc_s[k] = acc_s;
        end
    end

    // Expand group carries into per-bit carries and form the result flags.
    always_comb begin
        carry_s = {WIDTH{1'b0}};
        for (int k = 0; k < NG; k++) begin
            carry_s[4*k +: 4] = grp_carries(g1_r[4*k +: 4], p1_r[4*k +: 4], gc_s[k]);
        end
        sum_s  = p1_r ^ carry_s;
        cout_s = gc_s[NG];
        // Overflow: both addends share a sign and the result sign differs.
        ovf_s  = (sa1_r == sb1_r) && (sum_s[WIDTH-1] != sa1_r);
        zero_s = (sum_s == {WIDTH{1'b0}});
    end

    // Stage 2 register: result capture; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            v2_r   <= 1'b0;
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (s2_load_s) begin
            v2_r <= v1_r;
            // Keep the last result visible across bubbles.
            if (v1_r) begin
                sum_r  <= sum_s;
                cout_r <= cout_s;
                ovf_r  <= ovf_s;
                zero_r <= zero_s;
            end else begin
                sum_r  <= sum_r;
                cout_r <= cout_r;
                ovf_r  <= ovf_r;
                zero_r <= zero_r;
            end
        end else begin
            v2_r   <= v2_r;
            sum_r  <= sum_r;
            cout_r <= cout_r;
            ovf_r  <= ovf_r;
            zero_r <= zero_r;
        end
    end

    assign out_valid = v2_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// Self-checking bench for pipelined_cla_adder.
// Three instances (WIDTH = 4, 16, 64) share one stimulus stream. A queue-based
// reference keeps the expected results in acceptance order, computed with
// plain wide arithmetic, and one compare process checks every instance on
// every negative clock edge. Directed scenarios add literal expectations on
// the 16-bit instance.
// -----------------------------------------------------------------------------
module tb_pipelined_cla_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic        sub;
    logic [63:0] a_s;
    logic [63:0] b_s;

    logic        in_ready4,  out_valid4,  cout4,  ovf4,  zero4;
    logic        in_ready16, out_valid16, cout16, ovf16, zero16;
    logic        in_ready64, out_valid64, cout64, ovf64, zero64;
    logic [3:0]  sum4;
    logic [15:0] sum16;
    logic [63:0] sum64;

    pipelined_cla_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a_s[3:0]), .b(b_s[3:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid4), .out_ready(out_ready),
        .sum(sum4), .cout(cout4), .ovf(ovf4), .zero(zero4)
    );

    pipelined_cla_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a_s[15:0]), .b(b_s[15:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid16), .out_ready(out_ready),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    pipelined_cla_adder #(.WIDTH(64)) u_dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
        .a(a_s), .b(b_s), .cin(cin), .sub(sub),
        .out_valid(out_valid64), .out_ready(out_ready),
        .sum(sum64), .cout(cout64), .ovf(ovf64), .zero(zero64)
    );

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        res_t r4;
        res_t r16;
        res_t r64;
        bit   at_out;   // result is presented on the outputs
    } ent_t;

    ent_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   n_accept = 0;
    bit   cmp_en   = 1'b0;

    // Arithmetic reference: w-bit add/subtract with signed overflow computed
    // from the exact signed result range.
    function automatic res_t ref_op(input int w, input logic [63:0] x,
                                    input logic [63:0] y, input logic ci,
                                    input logic su);
        res_t               r;
        logic [65:0]        mask, ux, uy, full;
        logic signed [67:0] sx, sy, sci, exact, hi, lo;
        mask = (66'd1 << w) - 66'd1;
        ux   = {2'b00, x} & mask;
        uy   = {2'b00, y} & mask;
        full = su ? (ux + (~uy & mask) + 66'd1) : (ux + uy + {65'd0, ci});
        r.sum  = full[63:0] & mask[63:0];
        r.cout = full[w];
        sx = {2'b00, ux};
        if (ux[w-1]) sx = sx - (68'sd1 <<< w);
        sy = {2'b00, uy};
        if (uy[w-1]) sy = sy - (68'sd1 <<< w);
        sci   = {67'd0, ci};
        exact = su ? (sx - sy) : (sx + sy + sci);
        hi    = (68'sd1 <<< (w - 1)) - 68'sd1;
        lo    = -(68'sd1 <<< (w - 1));
        r.ovf  = (exact > hi) || (exact < lo);
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic chk_bit(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference pipeline: capacity two, in-order; the head reaches the outputs
    // one edge after it is alone at the front.
    always @(posedge clk) begin
        ent_t e;
        bit   acc;
        if (reset) begin
            q.delete();
        end else begin
            acc = in_valid && ((q.size() < 2) || out_ready);
            if (q.size() > 0 && q[0].at_out && out_ready) void'(q.pop_front());
            if (q.size() > 0 && !q[0].at_out) begin
                e = q[0];
                e.at_out = 1'b1;
                q[0] = e;
            end
            if (acc) begin
                e.r4     = ref_op(4,  a_s, b_s, cin, sub);
                e.r16    = ref_op(16, a_s, b_s, cin, sub);
                e.r64    = ref_op(64, a_s, b_s, cin, sub);
                e.at_out = 1'b0;
                q.push_back(e);
                n_accept++;
            end
        end
    end

    // Compare every instance against the reference on each falling edge.
    always @(negedge clk) begin
        bit exp_rdy;
        bit exp_ov;
        if (cmp_en) begin
            exp_rdy = (q.size() < 2) || out_ready;
            exp_ov  = (q.size() > 0) && q[0].at_out;
            chk_bit("in_ready4",  in_ready4,  exp_rdy);
            chk_bit("in_ready16", in_ready16, exp_rdy);
            chk_bit("in_ready64", in_ready64, exp_rdy);
            chk_bit("out_valid4",  out_valid4,  exp_ov);
            chk_bit("out_valid16", out_valid16, exp_ov);
            chk_bit("out_valid64", out_valid64, exp_ov);
            if (exp_ov) begin
                chk("sum4", {60'd0, sum4}, q[0].r4.sum);
                chk_bit("cout4", cout4, q[0].r4.cout);
                chk_bit("ovf4",  ovf4,  q[0].r4.ovf);
                chk_bit("zero4", zero4, q[0].r4.zero);
                chk("sum16", {48'd0, sum16}, q[0].r16.sum);
                chk_bit("cout16", cout16, q[0].r16.cout);
                chk_bit("ovf16",  ovf16,  q[0].r16.ovf);
                chk_bit("zero16", zero16, q[0].r16.zero);
                chk("sum64", sum64, q[0].r64.sum);
                chk_bit("cout64", cout64, q[0].r64.cout);
                chk_bit("ovf64",  ovf64,  q[0].r64.ovf);
                chk_bit("zero64", zero64, q[0].r64.zero);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation on an empty pipeline with literal expectations.
    task automatic do_op(input string nm, input logic [63:0] x, input logic [63:0] y,
                         input logic ci, input logic su, input logic [15:0] e_sum,
                         input logic e_cout, input logic e_ovf, input logic e_zero);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a_s = x; b_s = y; cin = ci; sub = su;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk_bit({nm, "_lat1_valid"}, out_valid16, 1'b0);
        @(negedge clk);
        chk_bit({nm, "_lat2_valid"}, out_valid16, 1'b1);
        chk({nm, "_sum"}, {48'd0, sum16}, {48'd0, e_sum});
        chk_bit({nm, "_cout"}, cout16, e_cout);
        chk_bit({nm, "_ovf"},  ovf16,  e_ovf);
        chk_bit({nm, "_zero"}, zero16, e_zero);
        step();
    endtask

    initial begin
        res_t r;
        int   target;
        int   cyc;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        cin = 1'b0; sub = 1'b0; a_s = 64'd0; b_s = 64'd0;

        // Hand-computed values pinning the reference itself.
        r = ref_op(16, 64'h1234, 64'h0FFF, 1'b1, 1'b0);
        chk("pin_add16_sum", r.sum, 64'h2234);
        chk_bit("pin_add16_cout", r.cout, 1'b0);
        r = ref_op(4, 64'hF, 64'h1, 1'b0, 1'b0);
        chk("pin_add4_sum", r.sum, 64'h0);
        chk_bit("pin_add4_cout", r.cout, 1'b1);
        chk_bit("pin_add4_zero", r.zero, 1'b1);
        r = ref_op(64, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        chk("pin_add64_sum", r.sum, 64'h8000_0000_0000_0000);
        chk_bit("pin_add64_ovf", r.ovf, 1'b1);
        r = ref_op(64, 64'h0, 64'h1, 1'b0, 1'b1);
        chk("pin_sub64_sum", r.sum, 64'hFFFF_FFFF_FFFF_FFFF);
        chk_bit("pin_sub64_cout", r.cout, 1'b0);
        chk_bit("pin_sub64_ovf",  r.ovf,  1'b0);

        // Reset state.
        step();
        cmp_en = 1'b1;
        step();
        @(negedge clk);
        chk_bit("rst_out_valid", out_valid16, 1'b0);
        chk_bit("rst_in_ready",  in_ready16,  1'b1);
        chk("rst_sum", {48'd0, sum16}, 64'd0);
        chk_bit("rst_cout", cout16, 1'b0);
        chk_bit("rst_ovf",  ovf16,  1'b0);
        chk_bit("rst_zero", zero16, 1'b0);
        step();
        reset = 1'b0;

        // Basic add, full carry chain, signed overflow for add and subtract.
        do_op("add_basic", 64'h1234, 64'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0, 1'b0);
        do_op("full_carry", 64'hFFFF, 64'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        do_op("ovf_add", 64'h7FFF, 64'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        do_op("ovf_sub", 64'h8000, 64'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

        // Back-to-back stream with a stalled consumer.
        out_ready = 1'b0; in_valid = 1'b1;
        a_s = 64'h1; b_s = 64'h2; cin = 1'b0; sub = 1'b0;
        step();
        a_s = 64'h10; b_s = 64'h20;
        step();
        a_s = 64'h100; b_s = 64'h1; sub = 1'b1;
        @(negedge clk);
        chk_bit("stall_in_ready_a", in_ready16, 1'b0);
        chk_bit("stall_valid_a", out_valid16, 1'b1);
        chk("stall_sum_a", {48'd0, sum16}, 64'h0003);
        step();
        @(negedge clk);
        chk_bit("stall_in_ready_b", in_ready16, 1'b0);
        chk("stall_sum_b", {48'd0, sum16}, 64'h0003);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk_bit("drain1_valid", out_valid16, 1'b1);
        chk("drain1_sum", {48'd0, sum16}, 64'h0030);
        step();
        @(negedge clk);
        chk_bit("drain2_valid", out_valid16, 1'b1);
        chk("drain2_sum", {48'd0, sum16}, 64'h00FF);
        chk_bit("drain2_cout", cout16, 1'b1);
        step();
        @(negedge clk);
        chk_bit("drain3_valid", out_valid16, 1'b0);
        step();

        // Reset with both stages full; input in the reset cycle is dropped.
        out_ready = 1'b0; in_valid = 1'b1; sub = 1'b0;
        a_s = 64'h5; b_s = 64'h6;
        step();
        a_s = 64'h7; b_s = 64'h8;
        step();
        @(negedge clk);
        chk_bit("full_in_ready", in_ready16, 1'b0);
        reset = 1'b1; out_ready = 1'b1; a_s = 64'h9; b_s = 64'h9;
        step();
        reset = 1'b0;
        a_s = 64'h3; b_s = 64'h5; cin = 1'b0; sub = 1'b1;
        @(negedge clk);
        chk_bit("midrst_out_valid", out_valid16, 1'b0);
        chk_bit("midrst_in_ready",  in_ready16,  1'b1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk_bit("midrst_no_stale", out_valid16, 1'b0);
        @(negedge clk);
        chk_bit("postrst_valid", out_valid16, 1'b1);
        chk("postrst_sum", {48'd0, sum16}, 64'hFFFE);
        chk_bit("postrst_cout", cout16, 1'b0);
        step();

        // Random traffic with random handshakes and occasional resets.
        target = n_accept + 10000;
        cyc    = 0;
        while (n_accept < target && cyc < 80000) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 70);
            a_s   = {$urandom, $urandom};
            b_s   = {$urandom, $urandom};
            cin   = $urandom_range(0, 1) == 1;
            sub   = $urandom_range(0, 1) == 1;
            reset = ($urandom_range(0, 999) == 0);
            step();
            cyc++;
        end
        checks++;
        if (n_accept < target) begin
            errors++;
            $display("FAIL random_budget: accepted %0d of required %0d", n_accept, target);
        end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
